// File: rtl/dadda_mul_arbiter_if.sv
// Request/response bus between the requesters, the consumer and the multiplier arbiter.
// master: requester/consumer side; slave: arbiter side.
interface dadda_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int OP_W  = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*OP_W-1:0]     rsp_data;
    logic [ID_W-1:0]       rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one combinational OP_W x OP_W multiplier among
// N_REQ requesters. One operation in flight; the product is captured after
// MUL_LAT enabled cycles and returned with the originating requester id.
// Optional feature macro: MUL_ARB_PERF_EN adds a 16-bit completed-op counter (op_count).
module dadda_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int OP_W    = 8,
    parameter int MUL_LAT = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    dadda_mul_arbiter_if.slave   bus,
    output logic                 mul_enable,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic [2*OP_W-1:0]    mul_out,
`ifdef MUL_ARB_PERF_EN
    output logic [15:0]          op_count,
`endif
    output logic                 busy
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_mul_a;
    logic [OP_W-1:0]     r_mul_b;
    logic                r_rsp_valid;
    logic [2*OP_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;

    logic                w_grant_any;
    logic [ID_W-1:0]     w_grant_id;
    logic [N_REQ-1:0]    w_grant_oh;
    logic [ID_W-1:0]     w_ptr_next;
    logic [OP_W-1:0]     w_sel_a;
    logic [OP_W-1:0]     w_sel_b;
    logic                w_last;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        idx         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_grant_any && bus.req_valid[idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = idx[ID_W-1:0];
            end
        end
    end

    assign w_grant_oh = w_grant_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_grant_id) : '0;
    assign w_ptr_next = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    assign w_sel_a    = bus.req_a[w_grant_id*OP_W +: OP_W];
    assign w_sel_b    = bus.req_b[w_grant_id*OP_W +: OP_W];
    assign w_last     = (r_cnt == CNT_W'(1));

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: accept in IDLE, count down in ISSUE, wait for consumer in RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_any)   w_next = ST_ISSUE;
            ST_ISSUE: if (w_last)        w_next = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Datapath: operand/id latch on accept, latency count, product capture, response hold.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_mul_a <= w_sel_a;
                        r_mul_b <= w_sel_b;
                        r_id    <= w_grant_id;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= CNT_W'(MUL_LAT);
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_rsp_data  <= mul_out;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_ARB_PERF_EN
    logic [15:0] r_op_count;

    // Completed-operation counter; wraps naturally at 16 bits.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_op_count <= '0;
        end else if (r_rsp_valid && bus.rsp_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    // Grant only in IDLE and never while reset is asserted.
    assign bus.req_ready = ((r_state == ST_IDLE) && !wb_rst_i) ? w_grant_oh : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign mul_enable    = (r_state == ST_ISSUE);
    assign mul_a         = r_mul_a;
    assign mul_b         = r_mul_b;
    assign busy          = (r_state != ST_IDLE);

endmodule
